// File: rtl/imm_pkg.sv
// Shared immediate-format definitions, used by the immediate decoder and the encoder.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: imm_src_t format selector, beat_t output beat, buf_state_t skid-buffer
// state, and fits_sext() for sign-extension legality checks.
package imm_pkg;

    localparam int IMM_W = 32;

    typedef enum logic [2:0] {
        IMM_NONE = 3'b000,
        IMM_I    = 3'b001,
        IMM_S    = 3'b010,
        IMM_B    = 3'b011,
        IMM_U    = 3'b100,
        IMM_J    = 3'b101
    } imm_src_t;

    // One encoded beat as it travels through the skid buffer.
    typedef struct packed {
        logic [IMM_W-1:0] instr;
        logic             err;
    } beat_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // True when v[31:lsb] are all equal, i.e. v is the sign extension of v[lsb:0].
    function automatic logic fits_sext(input logic [IMM_W-1:0] v, input int unsigned lsb);
        logic [IMM_W-1:0] mask;
        mask = {IMM_W{1'b1}} << lsb;
        return ((v & mask) == '0) || ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters a 32-bit immediate into a RISC-V instruction template and flags immediates
// the selected format cannot represent. Latency: 0 (purely combinational).
// Backpressure: none; output follows inputs in the same cycle.
//
// Ports: imm (sign-extended immediate), imm_src (format), base (template) ->
//        instr (template with immediate fields replaced), err (not representable).
// Optional macro IMM_ENCODE_RANGE_CHECK_EN: when undefined err is tied to 0 and no
// check logic is built; encoding is always by truncation.
module imm_pack
    import imm_pkg::*;
(
    input  logic [IMM_W-1:0] imm,
    input  imm_src_t         imm_src,
    input  logic [IMM_W-1:0] base,
    output logic [IMM_W-1:0] instr,
    output logic             err
);

    always_comb begin
        instr = base;
        case (imm_src)
            IMM_I: begin
                instr[31:20] = imm[11:0];
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
            end
            IMM_U: begin
                instr[31:12] = imm[31:12];
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
            end
            default: begin
                instr = base;
            end
        endcase
    end

`ifdef IMM_ENCODE_RANGE_CHECK_EN
    // B and J offsets are halfword-aligned, so bit 0 must be clear as well.
    always_comb begin
        err = 1'b0;
        case (imm_src)
            IMM_I, IMM_S: err = !fits_sext(imm, 11);
            IMM_B:        err = imm[0] || !fits_sext(imm, 12);
            IMM_U:        err = (imm[11:0] != 12'd0);
            IMM_J:        err = imm[0] || !fits_sext(imm, 20);
            default:      err = 1'b0;
        endcase
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/imm_encode.sv
// Immediate encoder: immediate + format + template in, encoded instruction word out.
// Latency: 1 cycle from accept to out_valid when empty or draining; 1 beat/cycle throughput.
// Backpressure: two-entry skid buffer; in_ready is registered (low only when both entries full).
//
// Ports: clk, rst_n (synchronous, active low); in_valid/in_ready with in_imm, in_imm_src,
//        in_base; out_valid/out_ready with out_instr, out_err; err_count (saturating count
//        of delivered beats flagged out_err). Only DATA_WIDTH = 32 is supported.
// Optional macro IMM_ENCODE_RANGE_CHECK_EN: enables out_err and err_count; when undefined
// both are constant 0.
module imm_encode
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [2:0]            in_imm_src,
    input  logic [DATA_WIDTH-1:0] in_base,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic                  out_err,
    output logic [CNT_WIDTH-1:0]  err_count
);

    buf_state_t state_q, state_d;
    beat_t      out_q, out_d;
    beat_t      skid_q, skid_d;
    beat_t      new_beat;
    logic       accept;
    logic       drain;

    imm_pack u_pack (
        .imm     (in_imm),
        .imm_src (imm_src_t'(in_imm_src)),
        .base    (in_base),
        .instr   (new_beat.instr),
        .err     (new_beat.err)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: outputs depend on state only, so in_ready has no path from out_ready.
    always_comb begin
        in_ready  = (state_q != BUF_TWO);
        out_valid = (state_q != BUF_EMPTY);
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: if (accept) state_d = BUF_ONE;
            BUF_ONE: begin
                if (accept && !drain)      state_d = BUF_TWO;
                else if (drain && !accept) state_d = BUF_EMPTY;
            end
            BUF_TWO:   if (drain) state_d = BUF_ONE;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    // Datapath: the output register loads a new beat only when it is empty or being
    // drained; otherwise the new beat parks in the skid register.
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        case (state_q)
            BUF_EMPTY: if (accept) out_d = new_beat;
            BUF_ONE: begin
                if (accept && drain)       out_d  = new_beat;
                else if (accept && !drain) skid_d = new_beat;
            end
            BUF_TWO:   if (drain) out_d = skid_q;
            default: begin
                out_d  = out_q;
                skid_d = skid_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

    assign out_instr = out_q.instr;
    assign out_err   = out_q.err;

`ifdef IMM_ENCODE_RANGE_CHECK_EN
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (drain && out_q.err && (err_count_q != {CNT_WIDTH{1'b1}})) begin
            err_count_d = err_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encode.sv
module tb_imm_encode;

`ifdef IMM_ENCODE_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [2:0]  in_imm_src;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_count;

    int tests = 0;
    int fails = 0;

    logic [32:0] exp_q[$];     // {err, instr} of every accepted, undelivered beat
    logic [15:0] model_cnt;

    always #5 clk = ~clk;

    imm_encode #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_imm     (in_imm),
        .in_imm_src (in_imm_src),
        .in_base    (in_base),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .err_count  (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: field placement written as masks/shifts, legality as signed ranges.
    function automatic logic [32:0] model(input logic [31:0] imm, input logic [2:0] src,
                                          input logic [31:0] base);
        int          v;
        logic [31:0] ins;
        logic        bad;
        v   = $signed(imm);
        ins = base;
        bad = 1'b0;
        case (src)
            3'd1: begin
                ins = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
                bad = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                ins = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                bad = (v < -2048) || (v > 2047);
            end
            3'd3: begin
                ins = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                    | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 32'h1) << 7);
                bad = ((v % 2) != 0) || (v < -4096) || (v > 4095);
            end
            3'd4: begin
                ins = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
                bad = ((imm % 4096) != 0);
            end
            3'd5: begin
                ins = (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31)
                    | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                    | (imm & 32'h000F_F000);
                bad = ((v % 2) != 0) || (v < -1048576) || (v > 1048575);
            end
            default: begin
                ins = base;
                bad = 1'b0;
            end
        endcase
        return {bad & CHK, ins};
    endfunction

    function automatic logic [31:0] rand_imm();
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom);
            1:       v = int'($urandom_range(0, 8191)) - 4096;
            2:       v = int'($urandom_range(0, 2097151)) - 1048576;
            default: v = int'($urandom & 32'hFFFF_F000);
        endcase
        return v;
    endfunction

    // One clock: drive inputs, score handshakes before the edge, check state after it.
    task automatic step(input logic iv, input logic [31:0] imm, input logic [2:0] src,
                        input logic [31:0] base, input logic ordy, output logic acc);
        logic [32:0] e;
        logic        hold;
        logic [31:0] hold_instr;
        logic        hold_err;
        in_valid   = iv;
        in_imm     = imm;
        in_imm_src = src;
        in_base    = base;
        out_ready  = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_instr", out_instr, e[31:0]);
                check("out_err", 32'(out_err), 32'(e[32]));
                if (e[32] && model_cnt != 16'hFFFF) model_cnt++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(imm, src, base));
        hold       = out_valid && !out_ready;
        hold_instr = out_instr;
        hold_err   = out_err;
        @(posedge clk); #1;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        check("err_count", 32'(err_count), 32'(model_cnt));
        if (hold) begin
            check("hold_instr", out_instr, hold_instr);
            check("hold_err", 32'(out_err), 32'(hold_err));
        end
    endtask

    logic [31:0] bimm [8];
    logic [2:0]  bsrc [8];

    initial begin
        logic acc;
        int   budget;
        rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_imm_src = '0; in_base = '0;
        out_ready = 1'b0; model_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;

        // Directed vectors with hand-derived encodings.
        step(1'b1, 32'hFFFF_FFFF, 3'd1, 32'h0000_0013, 1'b1, acc);
        check("tp_I_instr", out_instr, 32'hFFF0_0013);
        check("tp_I_err", 32'(out_err), 32'd0);
        step(1'b1, 32'hFFFF_FFFC, 3'd3, 32'h0000_0063, 1'b1, acc);
        check("tp_B_instr", out_instr, 32'hFE00_0EE3);
        check("tp_B_err", 32'(out_err), 32'd0);
        step(1'b1, 32'h1234_5001, 3'd4, 32'h0000_0537, 1'b1, acc);
        check("tp_U_instr", out_instr, 32'h1234_5537);
        check("tp_U_err", 32'(out_err), 32'(CHK));
        step(1'b1, 32'h0010_0000, 3'd5, 32'h0000_006F, 1'b1, acc);
        check("tp_U_cnt", 32'(err_count), 32'(CHK));
        check("tp_J_bad_err", 32'(out_err), 32'(CHK));
        step(1'b1, 32'h000F_FFFE, 3'd5, 32'h0000_006F, 1'b1, acc);
        check("tp_J_ok_err", 32'(out_err), 32'd0);
        step(1'b0, '0, 3'd0, '0, 1'b1, acc);
        check("tp_J_cnt", 32'(err_count), 32'(CHK ? 2 : 0));

        // Range boundaries and the no-immediate formats.
        bimm = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'd4094, 32'd4095, 32'hFFFF_F000, 32'h000F_FFFE, 32'hDEAD_BEEF};
        bsrc = '{3'd1,     3'd2,     3'd1,          3'd3,     3'd3,     3'd3,          3'd5,          3'd6};
        for (int i = 0; i < 8; i++) step(1'b1, bimm[i], bsrc[i], 32'hA5A5_5A5A, 1'b1, acc);
        step(1'b1, 32'hFFFF_FFFF, 3'd7, 32'h1357_9BDF, 1'b1, acc);
        step(1'b1, 32'h8000_0000, 3'd0, 32'h0246_8ACE, 1'b1, acc);
        step(1'b0, '0, 3'd0, '0, 1'b1, acc);

        // Back-to-back with a stalled sink: fills to two, third beat waits.
        step(1'b1, 32'd5, 3'd1, 32'h0000_0093, 1'b0, acc);
        step(1'b1, 32'd6, 3'd2, 32'h0000_0023, 1'b0, acc);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 32'd7, 3'd1, 32'h0000_0013, 1'b0, acc);
        check("stall_no_accept", 32'(acc), 32'd0);
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 10) begin
            step(1'b1, 32'd7, 3'd1, 32'h0000_0013, 1'b1, acc);
            budget++;
        end
        check("third_beat_accepted", 32'(acc), 32'd1);
        repeat (3) step(1'b0, '0, 3'd0, '0, 1'b1, acc);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rand_imm(), 3'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 7), acc);
        end

        // Reset while full: everything buffered is discarded.
        step(1'b1, 32'h0000_1001, 3'd4, 32'h0000_0037, 1'b0, acc);
        step(1'b1, 32'h0000_0001, 3'd1, 32'h0000_0013, 1'b0, acc);
        step(1'b1, 32'h0000_0002, 3'd1, 32'h0000_0013, 1'b0, acc);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_out_instr", out_instr, 32'd0);
        check("midrst_out_err", 32'(out_err), 32'd0);
        exp_q.delete();
        model_cnt = '0;
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0, 3'd0, '0, 1'b1, acc);
        step(1'b1, 32'hFFFF_F800, 3'd2, 32'h0000_0023, 1'b1, acc);
        budget = 0;
        while (exp_q.size() != 0 && budget < 10) begin
            step(1'b0, '0, 3'd0, '0, 1'b1, acc);
            budget++;
        end
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
